regfile_mp: RTL and testbench

Parametrised multi-port general-purpose register file for the RISC core. It is the successor to the fixed 32x32 two-read/one-write file, with configurable data width, depth and read-port count, and two write ports. It adds a per-register busy scoreboard for pending writebacks and a hardware clear sequencer that zeroes storage over DEPTH cycles after reset or on request. It sits between decode (reads, claims) and writeback (two retire lanes).

---
 rtl/regfile_mp.sv | 170 +++++++++++++++++
 tb/tb_regfile_mp.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp -- parametrised multi-port register file with busy scoreboard
//               and hardware clear sequencer.
//
// Two write lanes (A, B) from writeback, NRD combinational read ports and a
// claim port from decode. After reset, or on clr_i while idle, a sequencer
// zeroes one entry per cycle. Reads return 0 and the scoreboard reports
// nothing busy until the sequencer finishes.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : reads forward same-cycle write data (lane B over lane A)
//   undefined : reads see stored contents only; writes visible next cycle
//
// Ports
//   clk          in   clock, all state on rising edge
//   rst          in   asynchronous, active-low reset
//   clr_i        in   start a clear sequence (sampled only when idle)
//   ready_o      out  1 = idle, file usable
//   dbg_state_o  out  sequencer state (0 = CLEAR, 1 = IDLE)
//   rd_addr_i    in   NRD read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data_o    out  NRD read data words, combinational
//   rd_busy_o    out  busy bit of each read address, combinational
//   wa_*/wb_*    in   write lane A / lane B enable, address, data
//   claim_en_i   in   mark claim_addr_i busy (pending writeback)
//   claim_addr_i in   register to mark
//
// ready_o is a level, not a handshake: while it is 0 every write and claim
// is dropped and every read returns 0; while it is 1 all inputs are acted
// on in the cycle they are presented.
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NRD     = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    output logic                  ready_o,
    output logic                  dbg_state_o,
    input  logic [NRD*ADDR_W-1:0] rd_addr_i,
    output logic [NRD*DATA_W-1:0] rd_data_o,
    output logic [NRD-1:0]        rd_busy_o,
    input  logic                  wa_en_i,
    input  logic [ADDR_W-1:0]     wa_addr_i,
    input  logic [DATA_W-1:0]     wa_data_i,
    input  logic                  wb_en_i,
    input  logic [ADDR_W-1:0]     wb_addr_i,
    input  logic [DATA_W-1:0]     wb_data_i,
    input  logic                  claim_en_i,
    input  logic [ADDR_W-1:0]     claim_addr_i
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZR    = (ZERO_R0 != 0);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    logic [0:0]        state_q, state_d;
    // One extra bit so the counter reaches DEPTH instead of wrapping to 0.
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic idle;
    logic upd_ok;
    logic wa_ok;
    logic wb_ok;
    logic cl_ok;
    logic clr_wr;

    assign idle   = (state_q == ST_IDLE);
    // A clear request in the same cycle wins over writes and claims.
    assign upd_ok = idle && !clr_i;
    assign wa_ok  = upd_ok && wa_en_i    && !(ZR && (wa_addr_i    == '0));
    assign wb_ok  = upd_ok && wb_en_i    && !(ZR && (wb_addr_i    == '0));
    assign cl_ok  = upd_ok && claim_en_i && !(ZR && (claim_addr_i == '0));
    assign clr_wr = (state_q == ST_CLEAR) && !cnt_q[ADDR_W];

    assign ready_o     = idle;
    assign dbg_state_o = state_q[0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            ST_CLEAR: begin
                // The edge after entry DEPTH-1 is zeroed hands over to IDLE.
                if (cnt_q[ADDR_W]) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + (ADDR_W+1)'(1);
                end
            end
            ST_IDLE: begin
                if (clr_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    busy_d  = '0;
                end else begin
                    if (wa_ok) busy_d[wa_addr_i] = 1'b0;
                    if (wb_ok) busy_d[wb_addr_i] = 1'b0;
                    // Applied last: a claim is a newer producer than a
                    // retiring write to the same register.
                    if (cl_ok) busy_d[claim_addr_i] = 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
                busy_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Storage has no reset; the clear sequencer zeroes it and reads are
    // masked until it is done, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem_q[cnt_q[ADDR_W-1:0]] <= '0;
        end else begin
            if (wa_ok) mem_q[wa_addr_i] <= wa_data_i;
            // Lane B is written after lane A so it wins on equal addresses.
            if (wb_ok) mem_q[wb_addr_i] <= wb_data_i;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rdat;
        logic              rbusy;

        assign ra = rd_addr_i[k*ADDR_W +: ADDR_W];

        always_comb begin
            rdat  = '0;
            rbusy = 1'b0;
            if (idle && !(ZR && (ra == '0))) begin
                rdat  = mem_q[ra];
                rbusy = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
                if (wb_ok && (wb_addr_i == ra)) begin
                    rdat = wb_data_i;
                end else if (wa_ok && (wa_addr_i == ra)) begin
                    rdat = wa_data_i;
                end
`endif
            end
        end

        assign rd_data_o[k*DATA_W +: DATA_W] = rdat;
        assign rd_busy_o[k]                  = rbusy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam bit ZR = 1'b1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT 0: defaults (32x32, 2 read ports) ----------------
  logic        clr;
  logic        ready, dbg;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wa_en, wb_en, cl_en;
  logic [4:0]  wa_addr, wb_addr, cl_addr;
  logic [31:0] wa_data, wb_data;

  regfile_mp u_dut (
    .clk(clk), .rst(rst_n), .clr_i(clr), .ready_o(ready), .dbg_state_o(dbg),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .claim_en_i(cl_en), .claim_addr_i(cl_addr)
  );

  // ---------------- DUT 4: 16x64, 4 read ports ----------------
  logic         ready4, dbg4;
  logic [15:0]  rd_addr4;
  logic [255:0] rd_data4;
  logic [3:0]   rd_busy4;
  logic         wa_en4, wb_en4, cl_en4;
  logic [3:0]   wa_addr4, wb_addr4, cl_addr4;
  logic [63:0]  wa_data4, wb_data4;

  regfile_mp #(.DATA_W(64), .ADDR_W(4), .NRD(4)) u_dut4 (
    .clk(clk), .rst(rst_n), .clr_i(1'b0), .ready_o(ready4), .dbg_state_o(dbg4),
    .rd_addr_i(rd_addr4), .rd_data_o(rd_data4), .rd_busy_o(rd_busy4),
    .wa_en_i(wa_en4), .wa_addr_i(wa_addr4), .wa_data_i(wa_data4),
    .wb_en_i(wb_en4), .wb_addr_i(wb_addr4), .wb_data_i(wb_data4),
    .claim_en_i(cl_en4), .claim_addr_i(cl_addr4)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_mem [32];
  logic        m_busy [32];
  logic [63:0] m4_mem [16];
  logic        m4_busy [16];
  logic [63:0] exp_q [$];

  int    n_tests = 0;
  int    n_fail  = 0;
  string phase   = "init";

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s got=%h exp=%h", phase, tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
    for (int i = 0; i < 16; i++) begin m4_mem[i] = '0; m4_busy[i] = 1'b0; end
  endtask

  task automatic idle_inputs();
    clr = 1'b0;
    wa_en = 1'b0; wb_en = 1'b0; cl_en = 1'b0;
    wa_en4 = 1'b0; wb_en4 = 1'b0; cl_en4 = 1'b0;
  endtask

  // A register is writable/claimable unless it is the hard-wired zero.
  function automatic bit live0(input logic [4:0] a);
    return !(ZR && a == 5'd0);
  endfunction
  function automatic bit live4(input logic [3:0] a);
    return !(ZR && a == 4'd0);
  endfunction

  function automatic logic [31:0] exp_rd0(input logic [4:0] a);
    if (!live0(a)) return '0;
`ifdef REGFILE_BYPASS_EN
    if (!clr && wb_en && wb_addr == a) return wb_data;
    if (!clr && wa_en && wa_addr == a) return wa_data;
`endif
    return m_mem[a];
  endfunction

  function automatic logic [63:0] exp_rd4(input logic [3:0] a);
    if (!live4(a)) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wb_en4 && wb_addr4 == a) return wb_data4;
    if (wa_en4 && wa_addr4 == a) return wa_data4;
`endif
    return m4_mem[a];
  endfunction

  // What one clock edge does to the architectural state, in IDLE.
  task automatic model_edge();
    if (clr) begin
      for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
    end else begin
      if (wa_en && live0(wa_addr)) begin m_mem[wa_addr] = wa_data; m_busy[wa_addr] = 1'b0; end
      if (wb_en && live0(wb_addr)) begin m_mem[wb_addr] = wb_data; m_busy[wb_addr] = 1'b0; end
      if (cl_en && live0(cl_addr)) m_busy[cl_addr] = 1'b1;
    end
    if (wa_en4 && live4(wa_addr4)) begin m4_mem[wa_addr4] = wa_data4; m4_busy[wa_addr4] = 1'b0; end
    if (wb_en4 && live4(wb_addr4)) begin m4_mem[wb_addr4] = wb_data4; m4_busy[wb_addr4] = 1'b0; end
    if (cl_en4 && live4(cl_addr4)) m4_busy[cl_addr4] = 1'b1;
  endtask

  // One IDLE cycle: predict, sample at negedge, advance model at posedge.
  task automatic cycle();
    logic [4:0] a;
    logic [3:0] b;
    for (int k = 0; k < 2; k++) exp_q.push_back({32'd0, exp_rd0(rd_addr[k*5 +: 5])});
    for (int k = 0; k < 4; k++) exp_q.push_back(exp_rd4(rd_addr4[k*4 +: 4]));
    @(negedge clk);
    check_eq("ready", {63'd0, ready}, 64'd1);
    for (int k = 0; k < 2; k++) begin
      a = rd_addr[k*5 +: 5];
      check_eq($sformatf("rd%0d_r%0d", k, a), {32'd0, rd_data[k*32 +: 32]}, exp_q.pop_front());
      check_eq($sformatf("busy%0d_r%0d", k, a), {63'd0, rd_busy[k]}, {63'd0, m_busy[a]});
    end
    for (int k = 0; k < 4; k++) begin
      b = rd_addr4[k*4 +: 4];
      check_eq($sformatf("d4_rd%0d_r%0d", k, b), rd_data4[k*64 +: 64], exp_q.pop_front());
      check_eq($sformatf("d4_busy%0d", k), {63'd0, rd_busy4[k]}, {63'd0, m4_busy[b]});
    end
    @(posedge clk);
    model_edge();
    #1;
    idle_inputs();
  endtask

  // Watch a clear sequence from its first clear-state edge. A write and a
  // claim are attempted mid-sequence; they must be lost.
  task automatic watch_clear(input bit both);
    for (int e = 1; e <= 33; e++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq($sformatf("rdy_e%0d", e), {63'd0, ready}, {63'd0, (e == 33)});
      if (both) check_eq($sformatf("rdy4_e%0d", e), {63'd0, ready4}, {63'd0, (e >= 17)});
      if (e < 33) begin
        check_eq("clr_rd", rd_data, 64'd0);
        check_eq("clr_busy", {62'd0, rd_busy}, 64'd0);
      end
      if (e == 4) begin
        wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'hDEAD_BEEF;
        cl_en = 1'b1; cl_addr = 5'd9;
        rd_addr = {5'd9, 5'd9};
      end else begin
        wa_en = 1'b0; cl_en = 1'b0;
      end
    end
  endtask

  task automatic read_all0();
    for (int a = 0; a < 32; a += 2) begin
      rd_addr = {5'(a + 1), 5'(a)};
      cycle();
    end
  endtask

  function automatic logic [4:0] pick0();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
  endfunction

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    rd_addr = '0; rd_addr4 = '0;
    wa_addr = '0; wb_addr = '0; cl_addr = '0; wa_data = '0; wb_data = '0;
    wa_addr4 = '0; wb_addr4 = '0; cl_addr4 = '0; wa_data4 = '0; wb_data4 = '0;
    model_reset();

    // ---- reset state ----
    phase = "reset";
    repeat (3) @(posedge clk);
    rd_addr = {5'd3, 5'd1};
    #1;
    check_eq("ready", {63'd0, ready}, 64'd0);
    check_eq("ready4", {63'd0, ready4}, 64'd0);
    check_eq("rd", rd_data, 64'd0);
    check_eq("busy", {62'd0, rd_busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_clear(1'b1);
    idle_inputs();
    phase = "post_reset";
    read_all0();

    // ---- same-address dual write: lane B wins ----
    phase = "dual_wr";
    rd_addr = {5'd0, 5'd5};
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h0000_1234;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_ABCD;
    cycle();
    cycle();
    check_eq("r5_model", {32'd0, m_mem[5]}, 64'h0000_ABCD);

    // ---- claim r7, write 3 cycles later ----
    phase = "claim";
    rd_addr = {5'd0, 5'd7};
    cl_en = 1'b1; cl_addr = 5'd7;
    cycle();
    repeat (3) cycle();
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h55;
    cycle();
    cycle();
    phase = "claim_same";
    cl_en = 1'b1; cl_addr = 5'd7; wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h66;
    cycle();
    cycle();
    check_eq("r7_busy_model", {63'd0, m_busy[7]}, 64'd1);

    // ---- r0 is hard zero ----
    phase = "r0";
    rd_addr = {5'd0, 5'd0};
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFF_FFFF;
    cl_en = 1'b1; cl_addr = 5'd0;
    cycle();
    cycle();

    // ---- fill r1..r31, then clear ----
    phase = "fill";
    for (int a = 1; a < 32; a++) begin
      if (a % 2 == 1) begin wa_en = 1'b1; wa_addr = 5'(a); wa_data = $urandom; end
      else begin wb_en = 1'b1; wb_addr = 5'(a); wb_data = $urandom; end
      cl_en = 1'b1; cl_addr = 5'($urandom_range(1, 31));
      rd_addr = {5'(a), pick0()};
      cycle();
    end
    read_all0();
    phase = "clr";
    clr = 1'b1;
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h1111_2222;
    cl_en = 1'b1; cl_addr = 5'd4;
    rd_addr = {5'd4, 5'd3};
    cycle();
    watch_clear(1'b0);
    idle_inputs();
    phase = "post_clr";
    read_all0();

    // ---- randomized traffic on both DUTs ----
    phase = "rand";
    for (int i = 0; i < 400; i++) begin
      wa_en = 1'($urandom_range(0, 1)); wa_addr = pick0(); wa_data = $urandom;
      wb_en = 1'($urandom_range(0, 1)); wb_addr = pick0(); wb_data = $urandom;
      cl_en = ($urandom_range(0, 2) == 0); cl_addr = pick0();
      rd_addr = {($urandom_range(0, 1) == 1) ? wb_addr : pick0(), pick0()};
      wa_en4 = 1'($urandom_range(0, 1)); wa_addr4 = 4'($urandom_range(0, 15));
      wa_data4 = {$urandom, $urandom};
      wb_en4 = 1'($urandom_range(0, 1)); wb_addr4 = 4'($urandom_range(0, 15));
      wb_data4 = {$urandom, $urandom};
      cl_en4 = ($urandom_range(0, 2) == 0); cl_addr4 = 4'($urandom_range(0, 15));
      rd_addr4 = {wb_addr4, wa_addr4, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      cycle();
    end

    // ---- reset 10 cycles into a clear sequence ----
    phase = "rst_mid_clr";
    clr = 1'b1;
    cycle();
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check_eq("ready", {63'd0, ready}, 64'd0);
    check_eq("ready4", {63'd0, ready4}, 64'd0);
    check_eq("rd4", rd_data4[63:0], 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    watch_clear(1'b1);
    idle_inputs();
    phase = "post_rst";
    read_all0();
    for (int a = 0; a < 16; a += 4) begin
      rd_addr4 = {4'(a + 3), 4'(a + 2), 4'(a + 1), 4'(a)};
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
